multiply: RTL and testbench
===========================

Name: multiply

Overview:
- Iterative signed 32x32 multiplier using shift-and-add on operand magnitudes, one multiplier bit per clock, with sign correction at the end.
- Used as the multi-cycle multiply unit beside the ALU; a level handshake (mult_begin / mult_end) links it to the issuing controller.
- Trades area for latency: one adder of width 2*WIDTH and no array multiplier.

Parameters:
- WIDTH, 32, operand width; product is 2*WIDTH; the iteration count equals WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- resetn  input  1  asynchronous active-low reset.
- mult_begin  input  1  level request; held high for the whole operation and until the result is consumed.
- mult_op1  input  WIDTH  multiplicand, two's complement.
- mult_op2  input  WIDTH  multiplier, two's complement.
- product  output  2*WIDTH  signed product, registered.
- mult_end  output  1  result valid, registered.

Behaviour:
- Reset (resetn=0, async): state=IDLE; product=0; mult_end=0; internal accumulator, shift registers and counter cleared.
- States: IDLE, BUSY, DONE.
- IDLE, mult_begin=1 at an edge:
  - latch |op1| zero-extended into a 2*WIDTH multiplicand register.
  - latch |op2| into a WIDTH multiplier register.
  - latch sign = op1[MSB] ^ op2[MSB]; clear accumulator and counter; go BUSY.
- Operands are sampled only at this start edge; later changes are ignored.
- BUSY, each edge:
  - if multiplier[0], accumulator += multiplicand (mod 2^(2*WIDTH)).
  - multiplicand <<= 1; multiplier >>= 1; counter++.
  - after the WIDTH-th BUSY edge: product = sign ? -accumulator : accumulator; mult_end=1; go DONE.
- Latency: start edge N, mult_end high after edge N+WIDTH (32 cycles).
- DONE: product and mult_end held while mult_begin=1. When mult_begin=0 at an edge: mult_end=0, go IDLE. Product keeps the last result until the next completion.
- Abort: mult_begin=0 during BUSY means go IDLE at that edge; product unchanged; mult_end stays 0.
- mult_begin must drop for at least one edge between operations. No restart from DONE without passing through IDLE.
- |0x80000000| = 0x80000000 is treated unsigned in the magnitude path; the 64-bit result is exact for all input pairs.
- Reset mid-BUSY or in DONE returns to IDLE immediately, with outputs cleared.

Optional Feature:
- MULT_EARLY_TERM_EN defined: BUSY also exits to DONE at the first edge where the updated multiplier register is all zeros.
  - Latency becomes 1 + index of the highest set bit of |op2|, minimum 1 cycle (|op2|=0 or 1).
  - Result value is identical.
- Undefined: fixed latency of WIDTH cycles, independent of data.

Test Plan:
- Reset, then op1=0xF0000000, op2=0x00000002, begin held 40 cycles -> mult_end rises exactly 32 cycles after the start edge; product=0xFFFFFFFFE0000000. Drop begin -> mult_end=0 next edge; product holds.
- op1=0x80000000, op2=0x80000000 -> product=0x4000000000000000. Also op1=0xFFFFFFFF, op2=0xFFFFFFFF -> product=0x0000000000000001.
- op1=0x7FFFFFFF, op2=0x7FFFFFFF -> 0x3FFFFFFF00000001. Also op1=0x12345678, op2=0 -> product=0, mult_end after 32 cycles (1 cycle with MULT_EARLY_TERM_EN).
- Back-to-back random pairs, begin low 10 cycles between runs, operands changed mid-BUSY -> product equals signed 64-bit reference of the start-edge operands; mult_end never high in IDLE/BUSY.
- Abort: drop begin after 10 BUSY cycles -> no mult_end, product keeps the previous result. resetn pulsed low mid-BUSY -> product=0, mult_end=0 asynchronously; the next request completes normally.
- With MULT_EARLY_TERM_EN: op2=0x00000008, op1=0xFFFFFFFD -> product=0xFFFFFFFFFFFFFFE8, mult_end 4 cycles after the start edge.

Source files
------------

// File: rtl/multiply.sv
// Iterative signed WIDTH x WIDTH multiplier: shift-and-add on operand magnitudes, one bit per clock.
// Define MULT_EARLY_TERM_EN to finish as soon as the remaining multiplier bits are all zero.
module multiply #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 mult_begin,
  input  logic [WIDTH-1:0]     mult_op1,
  input  logic [WIDTH-1:0]     mult_op2,
  output logic [2*WIDTH-1:0]   product,
  output logic                 mult_end
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  logic [1:0]           state_q,   state_d;
  logic [2*WIDTH-1:0]   mcand_q,   mcand_d;
  logic [WIDTH-1:0]     mplier_q,  mplier_d;
  logic [2*WIDTH-1:0]   acc_q,     acc_d;
  logic [CW-1:0]        cnt_q,     cnt_d;
  logic                 sign_q,    sign_d;
  logic [2*WIDTH-1:0]   product_q, product_d;
  logic                 end_q,     end_d;

  logic [WIDTH-1:0]     op1_mag, op2_mag;
  logic [2*WIDTH-1:0]   acc_sum;
  logic [WIDTH-1:0]     mplier_shift;
  logic                 busy_last;

  // The most negative operand negates to itself; read as unsigned it is the correct magnitude.
  assign op1_mag      = mult_op1[WIDTH-1] ? -mult_op1 : mult_op1;
  assign op2_mag      = mult_op2[WIDTH-1] ? -mult_op2 : mult_op2;
  assign acc_sum      = mplier_q[0] ? acc_q + mcand_q : acc_q;
  assign mplier_shift = mplier_q >> 1;

`ifdef MULT_EARLY_TERM_EN
  assign busy_last = (cnt_q == LAST_CNT) || (mplier_shift == '0);
`else
  assign busy_last = (cnt_q == LAST_CNT);
`endif

  always_comb begin
    // NOTE: every next-state signal is defaulted to its register first, so no path leaves one unassigned (no latches).
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    sign_d    = sign_q;
    product_d = product_q;
    end_d     = end_q;

    case (state_q)
      ST_IDLE: begin
        if (mult_begin) begin
          mcand_d  = {{WIDTH{1'b0}}, op1_mag};
          mplier_d = op2_mag;
          sign_d   = mult_op1[WIDTH-1] ^ mult_op2[WIDTH-1];
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (!mult_begin) begin
          state_d = ST_IDLE;
        end else begin
          acc_d    = acc_sum;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_shift;
          cnt_d    = cnt_q + CW'(1);
          if (busy_last) begin
            product_d = sign_q ? -acc_sum : acc_sum;
            end_d     = 1'b1;
            state_d   = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        if (!mult_begin) begin
          end_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        end_d   = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      sign_q    <= 1'b0;
      product_q <= '0;
      end_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      sign_q    <= sign_d;
      product_q <= product_d;
      end_q     <= end_d;
    end
  end

  assign product  = product_q;
  assign mult_end = end_q;

endmodule

// File: tb/tb_multiply.sv
// Directed bench for the iterative multiplier: latency, signed results, hold/release, abort and reset.
module tb_multiply;

  logic        clk = 1'b0;
  logic        resetn;
  logic        mult_begin;
  logic [31:0] mult_op1;
  logic [31:0] mult_op2;
  logic [63:0] product;
  logic        mult_end;

  int checks = 0;
  int errors = 0;
  logic [63:0] last_prod;

  multiply #(.WIDTH(32)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .mult_begin (mult_begin),
    .mult_op1   (mult_op1),
    .mult_op2   (mult_op2),
    .product    (product),
    .mult_end   (mult_end)
  );

  always #5 clk = ~clk;

  function automatic int exp_lat(input logic [31:0] b);
`ifdef MULT_EARLY_TERM_EN
    logic [31:0] m;
    int l;
    m = b[31] ? -b : b;
    l = 1;
    for (int i = 0; i < 32; i++) if (m[i]) l = i + 1;
    return l;
`else
    return 32;
`endif
  endfunction

  // One full operation: start, scramble operands mid-run, wait for completion, hold, release, idle gap.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic [63:0] exp,
                       input int hold, input string name);
    int lat;
    bit seen;
    bit bad;
    @(negedge clk);
    mult_op1 = a; mult_op2 = b; mult_begin = 1'b1;
    @(posedge clk);
    lat = 0; seen = 1'b0;
    for (int k = 1; k <= 40 && !seen; k++) begin
      @(posedge clk); #1;
      if (mult_end) begin seen = 1'b1; lat = k; end
      if (k == 3) begin mult_op1 = ~a; mult_op2 = b ^ 32'h5A5A_A5A5; end
    end
    checks++;
    if (!seen || lat !== exp_lat(b)) begin
      errors++;
      $display("FAIL %s latency: got %0d (seen=%0d) expected %0d", name, lat, seen, exp_lat(b));
    end
    checks++;
    if (product !== exp) begin
      errors++;
      $display("FAIL %s product: got %h expected %h", name, product, exp);
    end
    bad = 1'b0;
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      if (mult_end !== 1'b1 || product !== exp) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL %s hold: mult_end=%b product=%h expected 1 / %h", name, mult_end, product, exp);
    end
    @(negedge clk); mult_begin = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (mult_end !== 1'b0 || product !== exp) begin
      errors++;
      $display("FAIL %s release: mult_end=%b product=%h expected 0 / %h", name, mult_end, product, exp);
    end
    bad = 1'b0;
    for (int k = 0; k < 9; k++) begin
      @(posedge clk); #1;
      if (mult_end !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL %s idle gap: mult_end went high while idle", name);
    end
    last_prod = exp;
  endtask

  task automatic test_reset();
    resetn = 1'b0; mult_begin = 1'b0; mult_op1 = 32'hDEAD_BEEF; mult_op2 = 32'h1234_5678;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (product !== 64'h0 || mult_end !== 1'b0) begin
      errors++;
      $display("FAIL reset: product=%h mult_end=%b expected 0 / 0", product, mult_end);
    end
    @(negedge clk); resetn = 1'b1;
  endtask

  task automatic test_basic();
    do_op(32'hF000_0000, 32'h0000_0002, 64'hFFFF_FFFF_E000_0000, 8, "neg_x_2");
  endtask

  task automatic test_corners();
    do_op(32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 2, "min_x_min");
    do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001, 2, "m1_x_m1");
    do_op(32'h7FFF_FFFF, 32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001, 2, "max_x_max");
    do_op(32'h1234_5678, 32'h0000_0000, 64'h0, 2, "x_zero");
    do_op(32'hFFFF_FFFD, 32'h0000_0008, 64'hFFFF_FFFF_FFFF_FFE8, 2, "m3_x_8");
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, b;
    logic [63:0] r;
    for (int i = 0; i < 6; i++) begin
      a = $urandom; b = $urandom;
      if (i == 0) b = 32'h0000_0001;
      r = 64'($signed(a)) * 64'($signed(b));
      do_op(a, b, r, 1, "rand");
    end
  endtask

  task automatic test_abort();
    bit bad;
    @(negedge clk);
    mult_op1 = 32'h0000_0003; mult_op2 = 32'h4000_0000; mult_begin = 1'b1;
    @(posedge clk);
    repeat (10) @(posedge clk);
    @(negedge clk); mult_begin = 1'b0;
    bad = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (mult_end !== 1'b0 || product !== last_prod) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL abort: mult_end=%b product=%h expected 0 / %h", mult_end, product, last_prod);
    end
  endtask

  task automatic test_reset_mid_busy();
    @(negedge clk);
    mult_op1 = 32'h0000_0003; mult_op2 = 32'h4000_0000; mult_begin = 1'b1;
    @(posedge clk);
    repeat (5) @(posedge clk);
    #2 resetn = 1'b0;
    #1;
    checks++;
    if (product !== 64'h0 || mult_end !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_busy: product=%h mult_end=%b expected 0 / 0", product, mult_end);
    end
    mult_begin = 1'b0;
    @(negedge clk); resetn = 1'b1;
    do_op(32'hFFFF_FFF9, 32'h0000_0006, 64'hFFFF_FFFF_FFFF_FFD6, 1, "after_reset");
  endtask

  initial begin
    last_prod = '0;
    test_reset();
    test_basic();
    test_corners();
    test_back_to_back();
    test_abort();
    test_reset_mid_busy();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
